// File: rtl/delay_tap_pkg.sv
// Shared types and helpers for the runtime-programmable delay line.
package delay_tap_pkg;

   typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

   // Out-of-range requests are pulled into [1, n_max].
   function automatic int clamp_delay(input int raw, input int n_max);
      if (raw <= 0)
         return 1;
      else if (raw > n_max)
         return n_max;
      else
         return raw;
   endfunction

endpackage

// File: rtl/delay_tap_ram.sv
// Sample storage: one synchronous write port, one asynchronous read port, no reset.
module delay_tap_ram #(
   parameter int N_MAX = 16,
   parameter int BITS  = 8,
   parameter int AW    = $clog2(N_MAX)
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [BITS-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr,
   output logic [BITS-1:0] o_rdata
);

   logic [BITS-1:0] mem [N_MAX];

   always_ff @(posedge i_clk) begin
      if (i_we)
         mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/delay_tap_reader.sv
// Circular-buffer delay line with a runtime-loadable delay and a valid flag.
// Optional macro DELAY_TAP_RANGE_ERR_EN adds a sticky o_range_err output.
module delay_tap_reader
   import delay_tap_pkg::*;
#(
   parameter int N_MAX = 16,
   parameter int BITS  = 8,
   parameter int DLY_W = $clog2(N_MAX+1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [BITS-1:0]  i_d,
   input  logic [DLY_W-1:0] i_delay,
   input  logic             i_delay_ld,
   output logic [BITS-1:0]  o_q,
   output logic             o_valid
`ifdef DELAY_TAP_RANGE_ERR_EN
   ,output logic            o_range_err
`endif
);

   localparam int AW = $clog2(N_MAX);
   localparam logic [AW:0] NM = (AW+1)'(N_MAX);

   state_t           state, state_nxt;
   logic [DLY_W-1:0] fill, fill_nxt;
   logic [DLY_W-1:0] dly, dly_ld;
   logic [AW-1:0]    wp, wp_nxt, rp;
   logic [AW:0]      rsum;
   logic [BITS-1:0]  q_reg, rd_data;

   assign dly_ld = DLY_W'(clamp_delay(int'(i_delay), N_MAX));

   // wp-(D-1) mod N_MAX, biased by N_MAX so the sum never underflows.
   always_comb begin
      rsum = (AW+1)'(wp) + NM + (AW+1)'(1) - (AW+1)'(dly);
      rp   = (rsum >= NM) ? AW'(rsum - NM) : AW'(rsum);
   end

   assign wp_nxt = (wp == AW'(N_MAX-1)) ? '0 : wp + AW'(1);

   delay_tap_ram #(.N_MAX(N_MAX), .BITS(BITS), .AW(AW)) u_ram (
      .i_clk   (i_clk),
      .i_we    (i_en),
      .i_waddr (wp),
      .i_wdata (i_d),
      .i_raddr (rp),
      .o_rdata (rd_data)
   );

   always_comb begin
      state_nxt = state;
      fill_nxt  = fill;
      if (i_delay_ld) begin
         fill_nxt  = i_en ? DLY_W'(1) : '0;
         state_nxt = (i_en && dly_ld == DLY_W'(1)) ? RUN : FILL;
      end else begin
         case (state)
            FILL: begin
               if (i_en) begin
                  fill_nxt = fill + DLY_W'(1);
                  if (fill + DLY_W'(1) == dly)
                     state_nxt = RUN;
               end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = FILL;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wp    <= '0;
         q_reg <= '0;
         fill  <= '0;
         dly   <= DLY_W'(N_MAX);
         state <= FILL;
      end else begin
         if (i_en) begin
            wp    <= wp_nxt;
            q_reg <= (dly == DLY_W'(1)) ? i_d : rd_data;
         end
         if (i_delay_ld)
            dly <= dly_ld;
         fill  <= fill_nxt;
         state <= state_nxt;
      end
   end

   assign o_valid = (state == RUN);
   assign o_q     = o_valid ? q_reg : '0;

`ifdef DELAY_TAP_RANGE_ERR_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_range_err <= 1'b0;
      else if (i_delay_ld && (int'(i_delay) != clamp_delay(int'(i_delay), N_MAX)))
         o_range_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_delay_tap_reader.sv
// Directed bench for delay_tap_reader: vector table plus ramp and reset sequences.
module tb_delay_tap_reader;

   localparam int N_MAX = 16;
   localparam int BITS  = 8;
   localparam int DLY_W = $clog2(N_MAX+1);

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [BITS-1:0]  d;
   logic [DLY_W-1:0] delay;
   logic             delay_ld;
   logic [BITS-1:0]  q;
   logic             valid;
`ifdef DELAY_TAP_RANGE_ERR_EN
   logic             range_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   delay_tap_reader #(.N_MAX(N_MAX), .BITS(BITS)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_d        (d),
      .i_delay    (delay),
      .i_delay_ld (delay_ld),
      .o_q        (q),
      .o_valid    (valid)
`ifdef DELAY_TAP_RANGE_ERR_EN
      ,.o_range_err (range_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             en;
      logic [BITS-1:0]  d;
      logic             ld;
      logic [DLY_W-1:0] dly;
      logic [BITS-1:0]  q;
      logic             v;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs, take one rising edge, sample 1 time unit later.
   task automatic step(input logic e, input logic [BITS-1:0] dd,
                       input logic l, input logic [DLY_W-1:0] dl);
      en = e; d = dd; delay_ld = l; delay = dl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // {en, d, ld, dly, exp_q, exp_valid}
      vecs[0]  = '{1'b0, 8'd0,   1'b1, 5'd3,  8'd0,   1'b0}; // load D=3
      vecs[1]  = '{1'b1, 8'd1,   1'b0, 5'd0,  8'd0,   1'b0};
      vecs[2]  = '{1'b1, 8'd2,   1'b0, 5'd0,  8'd0,   1'b0};
      vecs[3]  = '{1'b1, 8'd3,   1'b0, 5'd0,  8'd1,   1'b1};
      vecs[4]  = '{1'b1, 8'd4,   1'b0, 5'd0,  8'd2,   1'b1};
      vecs[5]  = '{1'b1, 8'd5,   1'b0, 5'd0,  8'd3,   1'b1};
      vecs[6]  = '{1'b0, 8'd99,  1'b0, 5'd0,  8'd3,   1'b1}; // idle hold
      vecs[7]  = '{1'b1, 8'd6,   1'b0, 5'd0,  8'd4,   1'b1};
      vecs[8]  = '{1'b0, 8'd0,   1'b1, 5'd4,  8'd0,   1'b0}; // load D=4
      vecs[9]  = '{1'b1, 8'd7,   1'b0, 5'd0,  8'd0,   1'b0};
      vecs[10] = '{1'b1, 8'd8,   1'b0, 5'd0,  8'd0,   1'b0};
      vecs[11] = '{1'b1, 8'd9,   1'b0, 5'd0,  8'd0,   1'b0};
      vecs[12] = '{1'b1, 8'd10,  1'b0, 5'd0,  8'd7,   1'b1};
      vecs[13] = '{1'b1, 8'd11,  1'b1, 5'd2,  8'd0,   1'b0}; // load 2 with en
      vecs[14] = '{1'b1, 8'd12,  1'b0, 5'd0,  8'd11,  1'b1};
      vecs[15] = '{1'b1, 8'd13,  1'b0, 5'd0,  8'd12,  1'b1};
      vecs[16] = '{1'b0, 8'd0,   1'b1, 5'd1,  8'd0,   1'b0}; // load D=1
      vecs[17] = '{1'b1, 8'hA5,  1'b0, 5'd0,  8'hA5,  1'b1};
      vecs[18] = '{1'b0, 8'h00,  1'b0, 5'd0,  8'hA5,  1'b1};
      vecs[19] = '{1'b1, 8'h3C,  1'b0, 5'd0,  8'h3C,  1'b1};
      vecs[20] = '{1'b0, 8'h00,  1'b0, 5'd0,  8'h3C,  1'b1};
      vecs[21] = '{1'b0, 8'd0,   1'b1, 5'd0,  8'd0,   1'b0}; // raw 0 -> D=1
      vecs[22] = '{1'b1, 8'h55,  1'b0, 5'd0,  8'h55,  1'b1};
      vecs[23] = '{1'b0, 8'd0,   1'b1, 5'd20, 8'd0,   1'b0}; // raw 20 -> D=16

      rst_n = 1'b0; en = 1'b0; d = '0; delay = '0; delay_ld = 1'b0;
      #12;
      chk("reset_q", int'(q), 0);
      chk("reset_valid", int'(valid), 0);
`ifdef DELAY_TAP_RANGE_ERR_EN
      chk("reset_range_err", int'(range_err), 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 24; i++) begin
         step(vecs[i].en, vecs[i].d, vecs[i].ld, vecs[i].dly);
         chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].q));
         chk($sformatf("vec%0d_valid", i), int'(valid), int'(vecs[i].v));
`ifdef DELAY_TAP_RANGE_ERR_EN
         if (i == 21 || i == 23)
            chk($sformatf("vec%0d_range_err", i), int'(range_err), 1);
`endif
      end

      // D = 16 ramp across the write-pointer wrap.
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, BITS'(k), 1'b0, '0);
         chk($sformatf("ramp16_%0d_valid", k), int'(valid), (k >= 16) ? 1 : 0);
         chk($sformatf("ramp16_%0d_q", k), int'(q), (k >= 16) ? k - 15 : 0);
      end

      // Asynchronous reset between edges while streaming in RUN.
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_q", int'(q), 0);
      chk("async_rst_valid", int'(valid), 0);
      #3;
      rst_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step(1'b1, BITS'(100 + k), 1'b0, '0);
         chk($sformatf("refill_%0d_valid", k), int'(valid), (k >= 16) ? 1 : 0);
         chk($sformatf("refill_%0d_q", k), int'(q), (k >= 16) ? 100 + k - 15 : 0);
      end
`ifdef DELAY_TAP_RANGE_ERR_EN
      chk("range_err_cleared", int'(range_err), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/delay_tap_reader.md
# delay_tap_reader

Runtime-programmable delay line for datapath alignment:
- Writes one sample per enabled cycle into a circular buffer.
- Returns the sample written D enables earlier, so D can be retuned without re-synthesis.
- Output sequence is cycle-identical to the fixed shift-register delay line with `N = D`, plus a valid flag that marks when real data reaches the output.
- Sits beside the fixed delay lines wherever a latency-matching path must track a configurable pipeline depth.

## Interface
Parameters:
- `N_MAX`, default 16 — maximum delay in enables; integer, 2 or more.
- `BITS`, default 8 — sample width.
- `DLY_W`, default `$clog2(N_MAX+1)` — width of the delay field.

Ports:
- `i_clk` — input, 1 — clock; all state is updated on the rising edge.
- `i_rst_n` — input, 1 — reset, asynchronous, active-low.
- `i_en` — input, 1 — advance; when high, the block writes `i_d` and updates `o_q`.
- `i_d` — input, `BITS` — input sample.
- `i_delay` — input, `DLY_W` — requested delay D. It is captured only when `i_delay_ld` is high.
- `i_delay_ld` — input, 1 — single-cycle pulse that loads `i_delay`.
- `o_q` — output, `BITS` — delayed sample; forced to 0 while `o_valid` is low.
- `o_valid` — output, 1 — high once D enables have occurred since the last reset or load.

## Operation
- Storage is an `N_MAX`-entry circular buffer with write pointer `wp`, which wraps from `N_MAX-1` to 0.
- On an enabled cycle, with D the currently effective delay:
  - `q_reg` ← `i_d` if D = 1.
  - Otherwise `q_reg` ← `mem[(wp-(D-1)) mod N_MAX]`, read before the write.
  - `mem[wp]` ← `i_d`.
  - `wp` ← `wp+1`.
- When `i_en` is low, the buffer, `wp`, `q_reg` and the fill counter all hold.
- Delay clamp on load:
  - A loaded value of 0 becomes 1.
  - A loaded value greater than `N_MAX` becomes `N_MAX`.
- Fill counter `fill` has width `DLY_W` and saturates at D.
- FSM states:
  - FILL: `fill` < D. Each enable increments `fill`. When `fill` reaches D, move to RUN.
  - RUN: `fill` = D. `o_valid` is 1. Stay in RUN until a load.
  - A load from either state: `fill` ← (`i_en` ? 1 : 0) and the FSM goes to FILL. If D = 1 and `i_en` = 1, the FSM goes straight to RUN.
- `o_q` = `o_valid` ? `q_reg` : 0. `o_valid` is decoded from the registered state, with no combinational path from the inputs.
- Buffer contents are preserved across a load. Only the valid tracking restarts.

## Timing
Reset:
- Asserting `i_rst_n` low clears `wp`, `q_reg` and `fill`, sets D = `N_MAX`, and puts the FSM in FILL, all immediately and asynchronously.
- During reset, `o_q` = 0 and `o_valid` = 0.
- The buffer array is not reset; output gating hides its contents.

Latency:
- The sample presented with the k-th enable appears on `o_q` in the cycle after the (k+D−1)-th enable.
- With continuous `i_en`, this is exactly D cycles.

Load:
- A load in cycle t makes the new D effective for enables from cycle t+1 onward.
- An enable in cycle t itself still uses the old D for its read.
- `o_valid` is 0 from cycle t+1 until the D-th counted enable after the load.

Other boundaries:
- A reset released in the middle of a stream resumes in FILL, with D = `N_MAX`.
- D = `N_MAX` reads `mem[wp+1]`, which is the oldest live entry. Read and write never address the same entry in the same cycle.

## Configuration
Macro `DELAY_TAP_RANGE_ERR_EN`:
- **Defined:** adds output `o_range_err` (1 bit).
  - It is a sticky flag, set in the cycle after a load whose raw `i_delay` was 0 or greater than `N_MAX`.
  - It is cleared only by reset; reset value 0.
  - Clamping still applies.
- **Undefined:** no port and no logic. Out-of-range values are clamped silently.

## Structure
- Package `delay_tap_pkg` holds:
  - The state enum {FILL, RUN}.
  - The function `clamp_delay(raw, n_max)`.
- Sub-module `delay_tap_ram`: `N_MAX` × `BITS` storage with one synchronous write port and one asynchronous read port, no reset. The top level owns the pointers, the FSM and the output register.

## Test plan
1. Reset, then `i_delay` = 3 loaded, then continuous `i_en` with `i_d` = 1,2,3,… → `o_valid` rises after the 3rd enable with `o_q` = 1, and `o_q` then tracks `i_d` − 3 each cycle.
2. D = 1, `i_en` toggling 1,0,1,0 with `i_d` = 0xA5, 0x00, 0x3C → `o_q` = 0xA5, holds through the idle cycle, then 0x3C. `o_valid` is high after the first enable.
3. D = `N_MAX` = 16 with a continuous ramp → first valid `o_q` = 1 after the 16th enable, and no read/write collision across the `wp` wrap (0..15, then 0).
4. In RUN with D = 4, load 2 together with `i_en` = 1 → `o_q` that cycle still uses delay 4, `o_valid` drops for one cycle, and data then lags by 2.
5. Load `i_delay` = 0, then load `i_delay` = 20 (`N_MAX` = 16) → effective D = 1 and then 16. With `DELAY_TAP_RANGE_ERR_EN` defined, `o_range_err` sets after the first load and stays set.
6. Assert `i_rst_n` low mid-stream between clock edges → `o_q` = 0 and `o_valid` = 0 immediately; after release, refill uses D = 16.
